// File: rtl/traffic_jam_if.sv
// Sensor/allow inputs and jam/queue status for the four-lane jam detector.
interface traffic_jam_if #(
  parameter int unsigned CNT_W = 6
);
  logic             car_arrive_0, car_arrive_1, car_arrive_2, car_arrive_3;
  logic             car_leave_0,  car_leave_1,  car_leave_2,  car_leave_3;
  logic             allow_0,      allow_1,      allow_2,      allow_3;
  logic             traffic_jam_0, traffic_jam_1, traffic_jam_2, traffic_jam_3;
  logic [CNT_W-1:0] queue_len_0,  queue_len_1,  queue_len_2,  queue_len_3;

  // Controller / sensor side
  modport master (
    output car_arrive_0, car_arrive_1, car_arrive_2, car_arrive_3,
    output car_leave_0,  car_leave_1,  car_leave_2,  car_leave_3,
    output allow_0,      allow_1,      allow_2,      allow_3,
    input  traffic_jam_0, traffic_jam_1, traffic_jam_2, traffic_jam_3,
    input  queue_len_0,  queue_len_1,  queue_len_2,  queue_len_3
  );

  // Detector side
  modport slave (
    input  car_arrive_0, car_arrive_1, car_arrive_2, car_arrive_3,
    input  car_leave_0,  car_leave_1,  car_leave_2,  car_leave_3,
    input  allow_0,      allow_1,      allow_2,      allow_3,
    output traffic_jam_0, traffic_jam_1, traffic_jam_2, traffic_jam_3,
    output queue_len_0,  queue_len_1,  queue_len_2,  queue_len_3
  );
endinterface

// File: rtl/traffic_jam_detector.sv
// Per-lane queue counter and hysteretic jam flag for a four-lane intersection.
// Optional STARVE_DETECT_EN also flags lanes that wait too long without green.
module traffic_jam_detector #(
  parameter int unsigned CNT_W      = 6,
  parameter int unsigned JAM_ON     = 20,
  parameter int unsigned JAM_OFF    = 8,
  parameter int unsigned HOLD_CYC   = 4,
  parameter int unsigned STARVE_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  traffic_jam_if.slave  bus
);

  localparam int unsigned HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam int unsigned WAIT_W = $clog2(STARVE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  if (JAM_OFF >= JAM_ON || HOLD_CYC < 1 || STARVE_CYC < 1 || WAIT_W < 1) begin : g_bad_cfg
    $error("traffic_jam_detector: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_PEND  = 2'd1,
    S_JAM   = 2'd2
  } jam_state_e;

  logic [3:0] arrive, leave, allow;

  assign arrive = {bus.car_arrive_3, bus.car_arrive_2, bus.car_arrive_1, bus.car_arrive_0};
  assign leave  = {bus.car_leave_3,  bus.car_leave_2,  bus.car_leave_1,  bus.car_leave_0};
  assign allow  = {bus.allow_3,      bus.allow_2,      bus.allow_1,      bus.allow_0};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [CNT_W-1:0]  q_len;
    logic [HOLD_W-1:0] hold;
    jam_state_e        state;
    logic              fsm_jam;
    logic              leave_eff;
    logic              jam_out;

    // Departures only count on green and with someone actually queued
    assign leave_eff = leave[i] & allow[i] & (q_len != '0);

    // Queue count plus CLEAR/PEND/JAM hysteresis; hold counts qualifying cycles seen so far
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q_len   <= '0;
        hold    <= '0;
        state   <= S_CLEAR;
        fsm_jam <= 1'b0;
      end else begin
        if (arrive[i] && !leave_eff) begin
          if (q_len != CNT_MAX) q_len <= q_len + CNT_W'(1);
        end else if (!arrive[i] && leave_eff) begin
          q_len <= q_len - CNT_W'(1);
        end

        case (state)
          S_CLEAR: begin
            if (q_len >= CNT_W'(JAM_ON)) begin
              if (HOLD_CYC <= 1) begin
                state   <= S_JAM;
                fsm_jam <= 1'b1;
              end else begin
                state <= S_PEND;
                hold  <= HOLD_W'(1);
              end
            end
          end
          S_PEND: begin
            if (q_len < CNT_W'(JAM_ON)) begin
              state <= S_CLEAR;
            end else if (hold == HOLD_W'(HOLD_CYC - 1)) begin
              state   <= S_JAM;
              fsm_jam <= 1'b1;
            end else begin
              hold <= hold + HOLD_W'(1);
            end
          end
          S_JAM: begin
            if (q_len <= CNT_W'(JAM_OFF)) begin
              state   <= S_CLEAR;
              fsm_jam <= 1'b0;
            end
          end
          default: begin
            state   <= S_CLEAR;
            fsm_jam <= 1'b0;
          end
        endcase
      end
    end

`ifdef STARVE_DETECT_EN
    logic [WAIT_W-1:0] wait_cnt;
    logic              starve;

    // Wait counter saturates at STARVE_CYC; starve mirrors wait_cnt == STARVE_CYC
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_cnt <= '0;
        starve   <= 1'b0;
      end else if (allow[i] || (q_len == '0)) begin
        wait_cnt <= '0;
        starve   <= 1'b0;
      end else if (wait_cnt != WAIT_W'(STARVE_CYC)) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
        starve   <= (wait_cnt == WAIT_W'(STARVE_CYC - 1));
      end
    end

    assign jam_out = fsm_jam | starve;
`else
    assign jam_out = fsm_jam;
`endif
  end

  assign bus.traffic_jam_0 = g_lane[0].jam_out;
  assign bus.traffic_jam_1 = g_lane[1].jam_out;
  assign bus.traffic_jam_2 = g_lane[2].jam_out;
  assign bus.traffic_jam_3 = g_lane[3].jam_out;

  assign bus.queue_len_0 = g_lane[0].q_len;
  assign bus.queue_len_1 = g_lane[1].q_len;
  assign bus.queue_len_2 = g_lane[2].q_len;
  assign bus.queue_len_3 = g_lane[3].q_len;

endmodule

// File: tb/tb_traffic_jam_detector.sv
// Directed bench for traffic_jam_detector with a per-cycle behavioural model.
module tb_traffic_jam_detector;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned JAM_ON     = 20;
  localparam int unsigned JAM_OFF    = 8;
  localparam int unsigned HOLD_CYC   = 4;
  localparam int unsigned STARVE_CYC = 64;
  localparam int          Q_MAX      = (1 << CNT_W) - 1;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] arr   = '0;
  logic [3:0] lv    = '0;
  logic [3:0] al    = '0;
  bit         cmp_en = 1'b0;

  int checks = 0;
  int errors = 0;

  traffic_jam_if #(.CNT_W(CNT_W)) bus ();

  assign bus.car_arrive_0 = arr[0];
  assign bus.car_arrive_1 = arr[1];
  assign bus.car_arrive_2 = arr[2];
  assign bus.car_arrive_3 = arr[3];
  assign bus.car_leave_0  = lv[0];
  assign bus.car_leave_1  = lv[1];
  assign bus.car_leave_2  = lv[2];
  assign bus.car_leave_3  = lv[3];
  assign bus.allow_0      = al[0];
  assign bus.allow_1      = al[1];
  assign bus.allow_2      = al[2];
  assign bus.allow_3      = al[3];

  traffic_jam_detector #(
    .CNT_W(CNT_W), .JAM_ON(JAM_ON), .JAM_OFF(JAM_OFF),
    .HOLD_CYC(HOLD_CYC), .STARVE_CYC(STARVE_CYC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [3:0] jam_dut;
  int         q_dut [4];
  assign jam_dut  = {bus.traffic_jam_3, bus.traffic_jam_2, bus.traffic_jam_1, bus.traffic_jam_0};
  assign q_dut[0] = int'(bus.queue_len_0);
  assign q_dut[1] = int'(bus.queue_len_1);
  assign q_dut[2] = int'(bus.queue_len_2);
  assign q_dut[3] = int'(bus.queue_len_3);

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue arithmetic, run length of cycles at/above JAM_ON, hysteresis on the flag
  int m_q [4];
  int m_run [4];
  bit m_jam [4];
  int m_wait [4];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        m_q[i] = 0; m_run[i] = 0; m_jam[i] = 1'b0; m_wait[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        int  q;
        bit  leff;
        q    = m_q[i];
        leff = lv[i] && al[i] && (q != 0);
        m_run[i] = (q >= int'(JAM_ON)) ? m_run[i] + 1 : 0;
        if (m_jam[i]) m_jam[i] = (q > int'(JAM_OFF));
        else          m_jam[i] = (m_run[i] >= int'(HOLD_CYC));
        if (al[i] || q == 0)                 m_wait[i] = 0;
        else if (m_wait[i] < int'(STARVE_CYC)) m_wait[i] = m_wait[i] + 1;
        if (arr[i] && !leff)      m_q[i] = (q < Q_MAX) ? q + 1 : Q_MAX;
        else if (!arr[i] && leff) m_q[i] = q - 1;
      end
    end
  end

  function automatic int exp_jam(input int i);
`ifdef STARVE_DETECT_EN
    return int'(m_jam[i] || (m_wait[i] == int'(STARVE_CYC)));
`else
    return int'(m_jam[i]);
`endif
  endfunction

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("queue_len_%0d", i), q_dut[i], m_q[i]);
        chk($sformatf("traffic_jam_%0d", i), int'(jam_dut[i]), exp_jam(i));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset
    repeat (2) tick();
    chk("reset_q0", q_dut[0], 0);
    chk("reset_jam", int'(jam_dut), 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // 1: 20 arrivals on lane 0, no green -> jam 4 cycles after queue reaches 20
    for (int k = 0; k < 20; k++) begin
      arr[0] = 1'b1; tick();
    end
    arr[0] = 1'b0;
    chk("t1_q0_20", q_dut[0], 20);
    chk("t1_jam0_t0", int'(jam_dut[0]), 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      chk($sformatf("t1_jam0_t%0d", k), int'(jam_dut[0]), 0);
    end
    tick();
    chk("t1_jam0_t4", int'(jam_dut[0]), 1);
    chk("t1_other_lanes", int'(jam_dut[3:1]), 0);

    // 2: green plus 12 departures -> jam holds at 9, drops after 8 seen
    al[0] = 1'b1;
    for (int k = 0; k < 11; k++) begin
      lv[0] = 1'b1; tick();
    end
    chk("t2_q0_9", q_dut[0], 9);
    chk("t2_jam0_at9", int'(jam_dut[0]), 1);
    tick();
    lv[0] = 1'b0;
    chk("t2_q0_8", q_dut[0], 8);
    chk("t2_jam0_q8_seen", int'(jam_dut[0]), 1);
    tick();
    chk("t2_jam0_cleared", int'(jam_dut[0]), 0);
    repeat (3) tick();

    // 3: queue at 20 for two cycles then drops to 19 -> pending aborts
    for (int k = 0; k < 20; k++) begin
      arr[1] = 1'b1; tick();
    end
    arr[1] = 1'b0;
    tick();
    al[1] = 1'b1; lv[1] = 1'b1; tick();
    lv[1] = 1'b0;
    chk("t3_q1_19", q_dut[1], 19);
    repeat (6) tick();
    chk("t3_jam1_never", int'(jam_dut[1]), 0);

    // 4: departure corner cases on lane 3
    al[3] = 1'b1; lv[3] = 1'b1; tick();
    lv[3] = 1'b0;
    chk("t4_leave_at_zero", q_dut[3], 0);
    arr[3] = 1'b1; tick();
    chk("t4_arrive", q_dut[3], 1);
    lv[3] = 1'b1; tick();
    chk("t4_arrive_and_leave", q_dut[3], 1);
    arr[3] = 1'b0; al[3] = 1'b0; tick();
    lv[3] = 1'b0;
    chk("t4_leave_no_green", q_dut[3], 1);

    // 5: saturation on lane 2, then asynchronous reset while jammed
    for (int k = 0; k < 70; k++) begin
      arr[2] = 1'b1; tick();
    end
    arr[2] = 1'b0;
    chk("t5_q2_sat", q_dut[2], Q_MAX);
    chk("t5_jam2", int'(jam_dut[2]), 1);
    tick();
    chk("t5_q2_no_wrap", q_dut[2], Q_MAX);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_jam", int'(jam_dut), 0);
    chk("t5_rst_q0", q_dut[0], 0);
    chk("t5_rst_q2", q_dut[2], 0);
    tick();
    rst_n = 1'b1;
    tick();

`ifdef STARVE_DETECT_EN
    // 6: one waiting car on lane 2 with no green -> starvation flag after STARVE_CYC cycles
    al[2] = 1'b0; arr[2] = 1'b1; tick();
    arr[2] = 1'b0;
    chk("t6_q2_1", q_dut[2], 1);
    repeat (STARVE_CYC - 1) tick();
    chk("t6_jam2_before", int'(jam_dut[2]), 0);
    tick();
    chk("t6_jam2_starved", int'(jam_dut[2]), 1);
    al[2] = 1'b1; tick();
    chk("t6_jam2_released", int'(jam_dut[2]), 0);
`endif

    repeat (3) tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
